// File: rtl/reb_pkg.sv
// Shared types and helpers for the Reduction_B stream collector.
// Frame geometry and FSM state encoding live here.
package reb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width that is never zero, so 1-entry ranges still get a real bus.
  function automatic int cwidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int frame_depth(input int d, input int ch);
    return d * d * ch;
  endfunction

endpackage

// File: rtl/reb_frame_ram.sv
// Frame buffer: one sync write port, one sync registered read port.
// The array itself is never reset; only the read register is.
module reb_frame_ram
  import reb_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 18,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [N];

  // capture one pixel word per write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // registered read; holds its value between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd <= '0;
    end else if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/reb_stream_collector.sv
// Captures one D x D x CH pixel frame from the Reduction_B stream
// and serves it through a registered random-access read port.
module reb_stream_collector
  import reb_pkg::*;
#(
  parameter int   data_width = 32,
  parameter int   D          = 17,
  parameter int   CH         = 4,
  localparam int  DEPTH      = frame_depth(D, CH),
  localparam int  ADDR_W     = cwidth(DEPTH),
  localparam int  CW         = cwidth(D),
  localparam int  HW         = cwidth(CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] pxl_in,
  input  logic                  frame_clr,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  frame_done,
  output logic                  ready,
  output logic                  busy,
  output logic                  overflow,
  output logic [CW-1:0]         col_cnt,
  output logic [CW-1:0]         row_cnt,
  output logic [HW-1:0]         ch_cnt
);

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [CW-1:0]     POS_MAX = CW'(D - 1);

  state_e                  state;
  logic [ADDR_W-1:0]       wr_addr;
  logic [CW-1:0]           col_nxt;
  logic [CW-1:0]           row_nxt;
  logic [HW-1:0]           ch_nxt;
  logic                    we;
  logic                    rd_ok;
  logic                    rd_in_range;
  logic                    rd_oor;
  logic [data_width-1:0]   ram_q;

  // Pixels land in the buffer only while a frame is still open.
  assign we          = valid_in && !frame_clr && (state != DONE);
  assign rd_ok       = rd_en && (state == DONE);
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;

  assign ready   = (state == DONE);
  assign busy    = (state == CAPTURE);
  assign rd_data = rd_oor ? '0 : ram_q;

  // raster position of the pixel after the current one
  always_comb begin
    col_nxt = col_cnt + 1'b1;
    row_nxt = row_cnt;
    ch_nxt  = ch_cnt;
    if (col_cnt == POS_MAX) begin
      col_nxt = '0;
      if (row_cnt == POS_MAX) begin
        row_nxt = '0;
        ch_nxt  = ch_cnt + 1'b1;
      end else begin
        row_nxt = row_cnt + 1'b1;
      end
    end
  end

  // capture FSM, position counters and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_addr    <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      ch_cnt     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_clr) begin
        state    <= IDLE;
        wr_addr  <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
        ch_cnt   <= '0;
        overflow <= 1'b0;
      end else if (valid_in) begin
        unique case (state)
          IDLE, CAPTURE: begin
            if (wr_addr == LAST_A) begin
              state      <= DONE;
              frame_done <= 1'b1;
              wr_addr    <= '0;
              col_cnt    <= '0;
              row_cnt    <= '0;
              ch_cnt     <= '0;
            end else begin
              state   <= CAPTURE;
              wr_addr <= wr_addr + 1'b1;
              col_cnt <= col_nxt;
              row_cnt <= row_nxt;
              ch_cnt  <= ch_nxt;
            end
          end
          DONE: begin
            overflow <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // read qualifier and out-of-range flag, updated per accepted read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_oor <= !rd_in_range;
      end
    end
  end

  reb_frame_ram #(
    .W  (data_width),
    .N  (DEPTH),
    .AW (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (wr_addr),
    .wd    (pxl_in),
    .re    (rd_ok && rd_in_range),
    .ra    (rd_addr),
    .rd    (ram_q)
  );

endmodule

// File: tb/tb_reb_stream_collector.sv
// Self-checking bench for reb_stream_collector (D=3, CH=2).
// Reference model: frame array plus accepted-pixel count.
module tb_reb_stream_collector;

  localparam int DW    = 32;
  localparam int D     = 3;
  localparam int CH    = 2;
  localparam int DEPTH = D * D * CH;
  localparam int AW    = 5;
  localparam int CW    = 2;
  localparam int HW    = 1;
  localparam logic [31:0] BASE = 32'h3c23d70a;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          frame_clr = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic          ready;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic [HW-1:0] ch_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  int          ref_n = 0;
  bit          ref_done = 1'b0;
  bit          ref_ovf = 1'b0;

  reb_stream_collector #(
    .data_width (DW),
    .D          (D),
    .CH         (CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .pxl_in     (pxl_in),
    .frame_clr  (frame_clr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .frame_done (frame_done),
    .ready      (ready),
    .busy       (busy),
    .overflow   (overflow),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt),
    .ch_cnt     (ch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    ref_n    = 0;
    ref_done = 1'b0;
    ref_ovf  = 1'b0;
  endtask

  // Drives one cycle of stream input and updates the reference model.
  task automatic push(input bit v, input logic [31:0] d, output bit fd);
    valid_in = v;
    pxl_in   = d;
    fd       = 1'b0;
    if (v && !ref_done) begin
      ref_mem[ref_n] = d;
      ref_n = ref_n + 1;
      if (ref_n == DEPTH) begin
        fd       = 1'b1;
        ref_done = 1'b1;
        ref_n    = 0;
      end
    end else if (v) begin
      ref_ovf = 1'b1;
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic do_clear();
    frame_clr = 1'b1;
    step();
    frame_clr = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks++;
    if ({rd_valid, frame_done, ready, busy, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {rd_valid, frame_done, ready, busy, overflow});
    end
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd_data got %h want 0", rd_data);
    end
    checks++;
    if (col_cnt !== '0 || row_cnt !== '0 || ch_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
               col_cnt, row_cnt, ch_cnt);
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_stream();
    bit fd;
    int fd_cnt = 0;
    int fd_at = -1;
    for (int i = 0; i < DEPTH; i++) begin
      push(1'b1, BASE + 32'(i), fd);
      checks++;
      if (frame_done !== fd) begin
        errors++;
        $display("FAIL stream_fd px %0d got %b want %b", i, frame_done, fd);
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_at = i + 1;
      end
      if (!fd) begin
        checks++;
        if (busy !== 1'b1 || col_cnt !== CW'(ref_n % D) ||
            row_cnt !== CW'((ref_n / D) % D) ||
            ch_cnt !== HW'(ref_n / (D * D))) begin
          errors++;
          $display("FAIL stream_pos n %0d got b%b %0d/%0d/%0d",
                   ref_n, busy, col_cnt, row_cnt, ch_cnt);
        end
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_at != DEPTH) begin
      errors++;
      $display("FAIL stream_fd_count got %0d@%0d want 1@%0d",
               fd_cnt, fd_at, DEPTH);
    end
    push(1'b0, '0, fd);
    checks++;
    if (frame_done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_after got fd%b r%b b%b want fd0 r1 b0",
               frame_done, ready, busy);
    end
  endtask

  task automatic test_read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[a]) begin
        errors++;
        $display("FAIL read_all addr %0d got v%b %h want v1 %h",
                 a, rd_valid, rd_data, ref_mem[a]);
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle got rd_valid %b want 0", rd_valid);
    end
  endtask

  task automatic test_gaps();
    bit fd;
    int cyc = 0;
    int fd_at = -1;
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      push(1'b1, BASE + 32'(i), fd);
      cyc++;
      checks++;
      if (frame_done !== fd) begin
        errors++;
        $display("FAIL gaps_fd cyc %0d got %b want %b", cyc, frame_done, fd);
      end
      if (frame_done === 1'b1) fd_at = cyc;
      if (i == 9) begin
        checks++;
        if (col_cnt !== 2'd1 || row_cnt !== 2'd0 || ch_cnt !== 1'b1) begin
          errors++;
          $display("FAIL gaps_px10 got %0d/%0d/%0d want 1/0/1",
                   col_cnt, row_cnt, ch_cnt);
        end
      end
      if (i < DEPTH - 1) begin
        push(1'b0, 32'hffff_ffff, fd);
        cyc++;
        checks++;
        if (frame_done !== 1'b0 || col_cnt !== CW'(ref_n % D) ||
            row_cnt !== CW'((ref_n / D) % D) ||
            ch_cnt !== HW'(ref_n / (D * D))) begin
          errors++;
          $display("FAIL gaps_hold cyc %0d got fd%b %0d/%0d/%0d",
                   cyc, frame_done, col_cnt, row_cnt, ch_cnt);
        end
      end
    end
    checks++;
    if (fd_at != 2 * DEPTH - 1) begin
      errors++;
      $display("FAIL gaps_fd_cycle got %0d want %0d", fd_at, 2 * DEPTH - 1);
    end
    test_read_all();
  endtask

  task automatic test_overflow();
    bit fd;
    push(1'b1, 32'hdeadbeef, fd);
    checks++;
    if (overflow !== 1'b1 || ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set got o%b r%b fd%b want o1 r1 fd0",
               overflow, ready, frame_done);
    end
    rd_en   = 1'b1;
    rd_addr = '0;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== BASE || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_mem0 got v%b %h want v1 %h", rd_valid, rd_data, BASE);
    end
    do_clear();
    checks++;
    if (overflow !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got o%b r%b b%b want 000", overflow, ready, busy);
    end
  endtask

  task automatic test_reset_mid_capture();
    bit fd;
    int fd_cnt = 0;
    int guard = 0;
    for (int i = 0; i < 7; i++) push(1'b1, $urandom, fd);
    checks++;
    if (busy !== 1'b1 || col_cnt !== 2'd1 || row_cnt !== 2'd2) begin
      errors++;
      $display("FAIL mid_pre got b%b %0d/%0d want b1 1/2", busy, col_cnt, row_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || col_cnt !== '0 ||
        row_cnt !== '0 || ch_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset got b%b r%b %0d/%0d/%0d want all 0",
               busy, ready, col_cnt, row_cnt, ch_cnt);
    end
    step();
    reset = 1'b1;
    model_clear();
    while (!ref_done && guard < 400) begin
      push(1'($urandom_range(0, 1)), $urandom, fd);
      guard++;
      checks++;
      if (frame_done !== fd) begin
        errors++;
        $display("FAIL rand_fd n %0d got %b want %b", ref_n, frame_done, fd);
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
    checks++;
    if (!ref_done || fd_cnt != 1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rand_frame got fd_cnt %0d ready %b want 1 1", fd_cnt, ready);
    end
    for (int k = 0; k < 24; k++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[a]) begin
        errors++;
        $display("FAIL rand_read addr %0d got %h want %h", a, rd_data, ref_mem[a]);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_rd_capture_and_range();
    bit fd;
    logic [31:0] prev;
    rd_en   = 1'b1;
    rd_addr = AW'(3);
    step();
    prev = ref_mem[3];
    rd_en = 1'b0;
    do_clear();
    push(1'b1, $urandom, fd);
    push(1'b1, $urandom, fd);
    rd_en   = 1'b1;
    rd_addr = '0;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== prev) begin
      errors++;
      $display("FAIL rd_capture got v%b %h want v0 %h", rd_valid, rd_data, prev);
    end
    while (!ref_done) push(1'b1, $urandom, fd);
    rd_en   = 1'b1;
    rd_addr = AW'(DEPTH);
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== '0) begin
      errors++;
      $display("FAIL rd_range got v%b %h want v1 0", rd_valid, rd_data);
    end
  endtask

  task automatic test_clr_with_valid();
    bit fd;
    logic [31:0] exp5;
    logic [31:0] x;
    exp5      = ref_mem[5];
    valid_in  = 1'b1;
    pxl_in    = 32'hdeadbeef;
    frame_clr = 1'b1;
    rd_en     = 1'b1;
    rd_addr   = AW'(5);
    step();
    valid_in  = 1'b0;
    frame_clr = 1'b0;
    rd_en     = 1'b0;
    model_clear();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp5) begin
      errors++;
      $display("FAIL clr_read got v%b %h want v1 %h", rd_valid, rd_data, exp5);
    end
    checks++;
    if (overflow !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_valid got o%b r%b b%b want 000", overflow, ready, busy);
    end
    x = $urandom;
    push(1'b1, x, fd);
    checks++;
    if (busy !== 1'b1 || col_cnt !== 2'd1) begin
      errors++;
      $display("FAIL clr_next got b%b col %0d want b1 col 1", busy, col_cnt);
    end
    while (!ref_done) push(1'b1, $urandom, fd);
    rd_en   = 1'b1;
    rd_addr = '0;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== x) begin
      errors++;
      $display("FAIL clr_addr0 got %h want %h", rd_data, x);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_read_all();
    test_gaps();
    test_overflow();
    test_reset_mid_capture();
    test_rd_capture_and_range();
    test_clr_with_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reb_stream_collector.md
# reb_stream_collector

Receive side of the serial feature-map pixel stream produced by the Reduction_B datapath. The block captures one full output frame (D×D pixels per channel, CH channels, channel-major, column-fastest raster) into an on-chip frame buffer. It tracks column, row and channel position and flags frame completion. It then serves the frame through a registered random-access read port to the next layer or host. It replaces file-dump sinks with synthesizable capture logic.

## Interface
Parameters:
- data_width, 32, pixel word width (IEEE-754 single, treated as opaque bits)
- D, 17, output spatial dimension (pixels per row and rows per channel)
- CH, 4, channels per frame
- ADDR_W, clog2(D*D*CH), buffer address width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  pixel strobe from the upstream valid_out
- pxl_in  in  data_width  pixel word from the upstream pxl_out
- frame_clr  in  1  single-cycle request to discard the frame and re-arm
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address (ch*D*D + row*D + col)
- rd_data  out  data_width  read data, registered
- rd_valid  out  1  rd_data qualifier
- frame_done  out  1  one-cycle pulse on capture of the last pixel
- ready  out  1  level, high while in DONE (frame readable)
- busy  out  1  level, high while in CAPTURE
- overflow  out  1  sticky: a pixel arrived while in DONE
- col_cnt / row_cnt  out  clog2(D)  position of the next expected pixel
- ch_cnt  out  clog2(CH)  channel of the next expected pixel

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - valid_in=1 writes pxl_in at address 0, advances counters and enters CAPTURE.
  - If DEPTH=1, it goes straight to DONE with frame_done.
- CAPTURE:
  - Each valid_in=1 writes mem[wr_addr] and increments wr_addr.
  - col_cnt wraps D-1→0 and increments row_cnt. row_cnt wraps D-1→0 and increments ch_cnt.
  - Gaps (valid_in=0) are allowed; counters hold.
  - The write at wr_addr = DEPTH-1 (DEPTH = D*D*CH) enters DONE, pulses frame_done and resets all counters to 0.
- DONE:
  - ready=1. Writes are blocked.
  - valid_in=1 sets overflow and drops the pixel.
- rd_en:
  - Honoured only in DONE: next cycle rd_valid=1 and rd_data=mem[rd_addr].
  - rd_addr ≥ DEPTH returns rd_data=0 with rd_valid=1.
  - rd_en outside DONE gives rd_valid=0 and rd_data holds its value.
- frame_clr:
  - Valid in any state: next state IDLE; counters, wr_addr and overflow cleared.
  - Buffer contents are not cleared.
  - frame_clr together with valid_in: clr wins, the pixel is dropped, overflow is not set.
  - frame_clr together with rd_en in DONE: the read completes (rd_valid next cycle).
- Reset:
  - Asserting reset at any time, including mid-capture, forces IDLE immediately.
  - Outputs reset to zero: rd_data, rd_valid, frame_done, ready, busy, overflow and all counters.
  - Memory is not reset.

## Timing
- Write: pixel sampled on the clk edge where valid_in=1. Counters and busy update on the same edge.
- frame_done: high for exactly the one cycle following the final pixel's edge. ready rises on that same edge.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data. Back-to-back reads every cycle are supported.
- A new frame cannot start until frame_clr returns the block to IDLE. The earliest accepted pixel is on the edge after the frame_clr edge.
- Throughput: one pixel per clock sustained; no backpressure to upstream.

## Structure
- Shared package reb_pkg:
  - state enum (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2)
  - clog2 function
  - frame-depth constant helper (D*D*CH)
- Sub-module reb_frame_ram, data_width × DEPTH:
  - one synchronous write port and one synchronous read port
  - read data registered
  - no reset on the array
- The top holds the FSM, counters, flags and read-range check.

## Test plan
- D=3, CH=2 (DEPTH=18); stream 18 consecutive words 32'h3c23d70a+i.
  - frame_done pulses once on cycle 18.
  - ready=1; reads of addr 0..17 return 32'h3c23d70a+addr with 1-cycle latency.
- Same stream with valid_in deasserted every other cycle.
  - frame_done is delayed to 35 cycles; contents are identical.
  - At pixel 10: col_cnt=1, row_cnt=0, ch_cnt=1.
- After DONE, drive valid_in=1 with 32'hdeadbeef.
  - overflow=1; mem[0] still 32'h3c23d70a; then frame_clr → overflow=0, ready=0.
- Reset low after pixel 7: state IDLE, all counters 0, busy=0.
  - A fresh 18-pixel frame then completes normally.
- rd_addr=18 in DONE → rd_data=0, rd_valid=1.
  - rd_en in CAPTURE → rd_valid stays 0.
- frame_clr together with valid_in in DONE: pixel dropped, overflow=0.
  - The next-cycle pixel is written at address 0.
